// File: rtl/raster_dispatch_pkg.sv
// Shared types for the triangle dispatcher: vertex/triangle layout and dispatch FSM states.
package raster_dispatch_pkg;

  localparam int WORD_W = 32;
  localparam int COMP   = 3;

  // Component 0 (x) sits in the least significant word.
  typedef logic [COMP-1:0][WORD_W-1:0] vertex_t;

  // Packed so that p1 lands in the LSBs of the host bus word.
  typedef struct packed {
    vertex_t p3;
    vertex_t p2;
    vertex_t p1;
  } triangle_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } dispatch_state_e;

endpackage

// File: rtl/raster_dispatch_if.sv
// Host-side queue port plus rasterizer start/done handshake and status, bundled for the dispatcher.
interface raster_dispatch_if
  import raster_dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);

  logic                      tri_valid;
  logic                      tri_ready;
  triangle_t                 tri_data;
  logic                      loop_en;
  logic                      flush;
  logic                      ru_start;
  vertex_t                   ru_p1;
  vertex_t                   ru_p2;
  vertex_t                   ru_p3;
  logic                      ru_done;
  logic                      busy;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic [CNT_W-1:0]          tri_cycles;
  logic                      tri_cycles_valid;
  logic                      timeout_err;

  // Master is the host plus the rasterizer; slave is the dispatcher itself.
  modport master (
    output tri_valid, tri_data, loop_en, flush, ru_done,
    input  tri_ready, ru_start, ru_p1, ru_p2, ru_p3, busy,
           fifo_count, tri_cycles, tri_cycles_valid, timeout_err
  );

  modport slave (
    input  tri_valid, tri_data, loop_en, flush, ru_done,
    output tri_ready, ru_start, ru_p1, ru_p2, ru_p3, busy,
           fifo_count, tri_cycles, tri_cycles_valid, timeout_err
  );

endinterface

// File: rtl/raster_dispatch_tri_fifo.sv
// Circular triangle queue; recirc moves the head entry to the tail without changing the count.
module tri_fifo
  import raster_dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_recirc,
  input  logic                   i_clear,
  input  triangle_t              i_data,
  output triangle_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  triangle_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (i_recirc)
        r_mem[r_wr_ptr] <= r_mem[r_rd_ptr];
      else if (i_push)
        r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_recirc) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end else begin
      if (i_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/raster_dispatch.sv
// Dispatches queued triangles one at a time to the rasterizer, with replay, flush,
// per-triangle cycle measurement and a done-timeout watchdog.
module raster_dispatch
  import raster_dispatch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              areset_n,
  raster_dispatch_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  dispatch_state_e  r_state;
  dispatch_state_e  w_next;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_tri_cycles;
  logic             r_tri_cycles_valid;
  logic             r_flush_pending;
  logic             r_timed_out;
  logic             r_timeout_err;
  vertex_t          r_p1;
  vertex_t          r_p2;
  vertex_t          r_p3;

  triangle_t        w_head;
  logic [CW-1:0]    w_count;
  logic             w_flush_any;
  logic             w_recirc;
  logic             w_clear;
  logic             w_pop;
  logic             w_push;
  logic             w_ready;
  logic             w_expired;

  // Host pushes are blocked while a flush is outstanding or the head is recirculating.
  always_comb begin
    w_cnt_inc   = (r_counter == '1) ? r_counter : r_counter + CNT_W'(1);
    w_flush_any = bus.flush || r_flush_pending;
    w_recirc    = (r_state == ST_RETIRE) && bus.loop_en && !r_timed_out && !w_flush_any;
    w_clear     = ((r_state == ST_IDLE) && bus.flush) || ((r_state == ST_RETIRE) && w_flush_any);
    w_pop       = (r_state == ST_RETIRE) && !w_recirc && !w_clear;
    w_ready     = ((w_count < CW'(DEPTH)) || w_pop) && !w_recirc && !w_flush_any;
    w_push      = bus.tri_valid && w_ready;
    w_expired   = (r_state == ST_WAIT) && !bus.ru_done && (r_counter == TIMEOUT_C);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if ((w_count != '0) && !bus.flush) w_next = ST_ISSUE;
      ST_ISSUE:  w_next = ST_WAIT;
      ST_WAIT:   if (bus.ru_done || w_expired) w_next = ST_RETIRE;
      ST_RETIRE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state            <= ST_IDLE;
      r_counter          <= '0;
      r_tri_cycles       <= '0;
      r_tri_cycles_valid <= 1'b0;
      r_flush_pending    <= 1'b0;
      r_timed_out        <= 1'b0;
      r_timeout_err      <= 1'b0;
      r_p1               <= '0;
      r_p2               <= '0;
      r_p3               <= '0;
    end else begin
      r_state            <= w_next;
      r_tri_cycles_valid <= 1'b0;
      if ((r_state == ST_ISSUE || r_state == ST_WAIT) && bus.flush)
        r_flush_pending <= 1'b1;
      else if (r_state == ST_RETIRE)
        r_flush_pending <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_ISSUE) begin
            r_p1 <= w_head.p1;
            r_p2 <= w_head.p2;
            r_p3 <= w_head.p3;
          end
        end
        ST_ISSUE: begin
          r_counter   <= CNT_W'(1);
          r_timed_out <= 1'b0;
        end
        ST_WAIT: begin
          r_counter <= w_cnt_inc;
          // The done cycle itself is counted in the reported latency.
          if (bus.ru_done) begin
            r_tri_cycles       <= w_cnt_inc;
            r_tri_cycles_valid <= 1'b1;
          end else if (w_expired) begin
            r_timed_out   <= 1'b1;
            r_timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_recirc (w_recirc),
    .i_clear  (w_clear),
    .i_data   (bus.tri_data),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  assign bus.tri_ready        = w_ready;
  assign bus.ru_start         = (r_state == ST_ISSUE);
  assign bus.ru_p1            = r_p1;
  assign bus.ru_p2            = r_p2;
  assign bus.ru_p3            = r_p3;
  assign bus.busy             = (r_state != ST_IDLE);
  assign bus.fifo_count       = w_count;
  assign bus.tri_cycles       = r_tri_cycles;
  assign bus.tri_cycles_valid = r_tri_cycles_valid;
  assign bus.timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_raster_dispatch.sv
// Directed bench for raster_dispatch: a small rasterizer model answers ru_start after a
// programmable delay, and a monitor logs which triangle each start pulse carried.
module tb_raster_dispatch;
  import raster_dispatch_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] F69  = 32'h428A0000;
  localparam logic [31:0] F169 = 32'h43290000;
  localparam logic [31:0] F1   = 32'h3F800000;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  int doneDelay = 0;
  int doneTimer = -1;
  logic [31:0] startLog [$];
  int validCount = 0;

  raster_dispatch_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) busIf ();

  raster_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (busIf.slave)
  );

  always #5 clk = ~clk;

  // Rasterizer model: ru_done is seen by the DUT exactly doneDelay cycles after ru_start.
  initial begin
    busIf.ru_done = 1'b0;
    forever begin
      @(negedge clk);
      busIf.ru_done = 1'b0;
      if (!areset_n)
        doneTimer = -1;
      else if (busIf.ru_start)
        doneTimer = (doneDelay > 0) ? doneDelay : -1;
      else if (doneTimer > 0) begin
        doneTimer--;
        if (doneTimer == 0) begin
          busIf.ru_done = 1'b1;
          doneTimer = -1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (areset_n && busIf.ru_start)
        startLog.push_back(busIf.ru_p1[0]);
      if (busIf.tri_cycles_valid)
        validCount++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic triangle_t makeTri(input logic [31:0] id);
    triangle_t t;
    t.p1 = {id, id, id};
    t.p2 = {~id, ~id, ~id};
    t.p3 = {id ^ 32'hA5A5A5A5, id, ~id};
    return t;
  endfunction

  task automatic applyStimulus(input triangle_t t, input int maxWait, output bit accepted);
    accepted = 1'b0;
    busIf.tri_data  = t;
    busIf.tri_valid = 1'b1;
    for (int i = 0; i < maxWait && !accepted; i++) begin
      #1;
      if (busIf.tri_ready)
        accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    busIf.tri_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    int startCount = validCount;
    int n = 0;
    while (validCount == startCount && n < maxCycles) begin
      tick();
      n++;
    end
    if (validCount == startCount)
      checkOutput({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n = 0;
    while ((busIf.busy || busIf.fifo_count != 0) && n < maxCycles) begin
      tick();
      n++;
    end
    if (busIf.busy || busIf.fifo_count != 0)
      checkOutput({tag, "_idle_timeout"}, 0, 1);
  endtask

  initial begin
    triangle_t t1;
    bit acc;
    int okCount;
    int v0;
    int n;

    busIf.tri_valid = 1'b0;
    busIf.tri_data  = '0;
    busIf.loop_en   = 1'b0;
    busIf.flush     = 1'b0;
    tick(3);
    areset_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_tri_ready", busIf.tri_ready, 1);
    checkOutput("rst_busy", busIf.busy, 0);
    checkOutput("rst_fifo_count", busIf.fifo_count, 0);
    checkOutput("rst_ru_start", busIf.ru_start, 0);
    checkOutput("rst_timeout_err", busIf.timeout_err, 0);
    checkOutput("rst_tri_cycles_valid", busIf.tri_cycles_valid, 0);
    checkOutput("rst_tri_cycles", busIf.tri_cycles, 0);
    checkOutput("rst_ru_p1", busIf.ru_p1, 0);

    $display("[TB] single triangle");
    startLog.delete();
    doneDelay = 10;
    t1.p1 = {F1, F69, F69};
    t1.p2 = {F1, F169, F69};
    t1.p3 = {F1, F69, F169};
    applyStimulus(t1, 4, acc);
    checkOutput("t1_accept", acc, 1);
    checkOutput("t1_count_queued", busIf.fifo_count, 1);
    tick();
    checkOutput("t1_ru_start", busIf.ru_start, 1);
    checkOutput("t1_ru_p1", busIf.ru_p1, {F1, F69, F69});
    checkOutput("t1_ru_p2", busIf.ru_p2, {F1, F169, F69});
    checkOutput("t1_ru_p3", busIf.ru_p3, {F1, F69, F169});
    tick();
    checkOutput("t1_start_pulse_width", busIf.ru_start, 0);
    waitValid("t1", 40);
    checkOutput("t1_tri_cycles", busIf.tri_cycles, 11);
    checkOutput("t1_count_empty", busIf.fifo_count, 0);
    checkOutput("t1_start_count", startLog.size(), 1);
    checkOutput("t1_busy_after", busIf.busy, 0);

    $display("[TB] full queue and ordering");
    startLog.delete();
    doneDelay = 12;
    v0 = validCount;
    okCount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(makeTri(32'(100 + i)), 4, acc);
      okCount += int'(acc);
    end
    checkOutput("t2_fill_accepts", okCount, DEPTH);
    checkOutput("t2_count_full", busIf.fifo_count, DEPTH);
    checkOutput("t2_ready_full", busIf.tri_ready, 0);
    applyStimulus(makeTri(32'd108), 3, acc);
    checkOutput("t2_ninth_held", acc, 0);
    checkOutput("t2_count_held", busIf.fifo_count, DEPTH);
    applyStimulus(makeTri(32'd108), 30, acc);
    checkOutput("t2_ninth_accepted", acc, 1);
    checkOutput("t2_accept_after_first_start", startLog.size(), 1);
    checkOutput("t2_accept_at_first_retire", validCount - v0, 1);
    checkOutput("t2_count_push_pop", busIf.fifo_count, DEPTH);
    waitIdle("t2", 200);
    checkOutput("t2_start_count", startLog.size(), 9);
    for (int i = 0; i < 9 && i < startLog.size(); i++)
      checkOutput($sformatf("t2_order_%0d", i), startLog[i], 100 + i);
    checkOutput("t2_tri_cycles", busIf.tri_cycles, 13);

    $display("[TB] loop mode");
    startLog.delete();
    doneDelay = 5;
    busIf.loop_en = 1'b1;
    applyStimulus(makeTri(32'd200), 4, acc);
    applyStimulus(makeTri(32'd201), 4, acc);
    n = 0;
    while (startLog.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("t3_start_count", startLog.size() >= 6, 1);
    checkOutput("t3_count_steady", busIf.fifo_count, 2);
    for (int i = 0; i < 6 && i < startLog.size(); i++)
      checkOutput($sformatf("t3_alternate_%0d", i), startLog[i], 200 + (i % 2));
    busIf.loop_en = 1'b0;
    waitIdle("t3", 60);

    $display("[TB] watchdog");
    startLog.delete();
    doneDelay = 0;
    v0 = validCount;
    applyStimulus(makeTri(32'd300), 4, acc);
    applyStimulus(makeTri(32'd301), 4, acc);
    n = 0;
    while (!busIf.ru_start && n < 10) begin
      tick();
      n++;
    end
    checkOutput("t4_start", busIf.ru_start, 1);
    checkOutput("t4_head", busIf.ru_p1[0], 300);
    tick(TIMEOUT);
    checkOutput("t4_no_err_early", busIf.timeout_err, 0);
    tick();
    checkOutput("t4_timeout_err", busIf.timeout_err, 1);
    checkOutput("t4_no_valid", busIf.tri_cycles_valid, 0);
    checkOutput("t4_busy_retire", busIf.busy, 1);
    doneDelay = 3;
    waitValid("t4", 30);
    checkOutput("t4_valid_only_next", validCount - v0, 1);
    checkOutput("t4_tri_cycles", busIf.tri_cycles, 4);
    checkOutput("t4_start_count", startLog.size(), 2);
    checkOutput("t4_next_issued", startLog.size() > 1 ? startLog[1] : 32'd0, 301);
    checkOutput("t4_err_sticky", busIf.timeout_err, 1);
    checkOutput("t4_dropped", busIf.fifo_count, 0);

    $display("[TB] flush during wait");
    startLog.delete();
    doneDelay = 8;
    applyStimulus(makeTri(32'd400), 4, acc);
    applyStimulus(makeTri(32'd401), 4, acc);
    applyStimulus(makeTri(32'd402), 4, acc);
    n = 0;
    while (startLog.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    tick(2);
    busIf.flush = 1'b1;
    #1;
    checkOutput("t5_ready_flush", busIf.tri_ready, 0);
    tick();
    busIf.flush = 1'b0;
    #1;
    checkOutput("t5_ready_pending", busIf.tri_ready, 0);
    checkOutput("t5_count_pending", busIf.fifo_count, 3);
    waitValid("t5", 20);
    checkOutput("t5_tri_cycles", busIf.tri_cycles, 9);
    checkOutput("t5_count_cleared", busIf.fifo_count, 0);
    tick(12);
    checkOutput("t5_no_more_starts", startLog.size(), 1);
    checkOutput("t5_busy", busIf.busy, 0);
    checkOutput("t5_ready_restored", busIf.tri_ready, 1);

    $display("[TB] reset mid-operation");
    startLog.delete();
    doneDelay = 0;
    applyStimulus(makeTri(32'd500), 4, acc);
    applyStimulus(makeTri(32'd501), 4, acc);
    tick(3);
    checkOutput("t6_busy_before", busIf.busy, 1);
    checkOutput("t6_err_before", busIf.timeout_err, 1);
    areset_n = 1'b0;
    #1;
    checkOutput("t6_busy", busIf.busy, 0);
    checkOutput("t6_fifo_count", busIf.fifo_count, 0);
    checkOutput("t6_ru_start", busIf.ru_start, 0);
    checkOutput("t6_timeout_err", busIf.timeout_err, 0);
    checkOutput("t6_tri_ready", busIf.tri_ready, 1);
    tick(2);
    areset_n = 1'b1;
    tick(3);
    checkOutput("t6_stays_idle", busIf.busy, 0);
    checkOutput("t6_count_after", busIf.fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
